// File: rtl/pad_mux_if.sv
// Pad mux bus bundle shared by the requester side (master) and the arbiter (slave).
// Ports:
//   enable_i, req_i, src_data_i, pad_in_i    requester side -> arbiter
//   grant_o, sel_o, mux_o, in_data_o,
//   in_valid_o, busy_o, preempt_o            arbiter -> requesters / pads
interface pad_mux_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned OUT_W = 18,
    parameter int unsigned IN_W  = 22
);
    logic                 enable_i;
    logic [N-1:0]         req_i;
    logic [N*OUT_W-1:0]   src_data_i;
    logic [IN_W-1:0]      pad_in_i;
    logic [N-1:0]         grant_o;
    logic [1:0]           sel_o;
    logic [OUT_W-1:0]     mux_o;
    logic [IN_W-1:0]      in_data_o;
    logic [N-1:0]         in_valid_o;
    logic                 busy_o;
    logic                 preempt_o;

    modport master (
        output enable_i, req_i, src_data_i, pad_in_i,
        input  grant_o, sel_o, mux_o, in_data_o, in_valid_o, busy_o, preempt_o
    );

    modport slave (
        input  enable_i, req_i, src_data_i, pad_in_i,
        output grant_o, sel_o, mux_o, in_data_o, in_valid_o, busy_o, preempt_o
    );
endinterface

// File: rtl/pad_mux_arbiter.sv
// Round-robin arbiter sharing the multiplexed pad bus between up to four requesters,
// with a hold-time limit (preemption when others wait) and a dead gap between owners.
// Ports:
//   clk_i   clock
//   rst_i   synchronous reset, active-high
//   bus     pad_mux_if.slave: enable_i/req_i/src_data_i/pad_in_i in;
//           grant_o/sel_o/in_data_o/in_valid_o/busy_o/preempt_o registered out;
//           mux_o combinational from registered owner state
module pad_mux_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned OUT_W       = 18,
    parameter int unsigned IN_W        = 22,
    parameter int unsigned MAX_HOLD    = 64,
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pad_mux_if.slave   bus
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned TURN_W = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [1:0]        LAST_RST  = 2'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_TURN = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [N-1:0]      grant_q,    grant_d;
    logic [1:0]        sel_q,      sel_d;
    logic [1:0]        last_q,     last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
    logic [IN_W-1:0]   in_data_q,  in_data_d;
    logic [N-1:0]      in_valid_q, in_valid_d;
    logic              busy_q,     busy_d;
    logic              preempt_q,  preempt_d;

    logic              win_found;
    logic [1:0]        win_idx;
    logic              owner_req;
    logic              others_req;

    // Round-robin search starting just after the last owner; descending loop so the
    // nearest requester (smallest offset) is the one left standing.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N; i >= 1; i--) begin
            cand = 2'((int'(last_q) + i) % N);
            if (bus.req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req  = |(bus.req_i & grant_q);
    assign others_req = |(bus.req_i & ~grant_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        preempt_d  = 1'b0;
        in_data_d  = bus.pad_in_i;
        in_valid_d = grant_q;

        case (state_q)
            S_IDLE: begin
                if (bus.enable_i && win_found) begin
                    state_d    = S_BUSY;
                    grant_d    = N'(1) << win_idx;
                    sel_d      = win_idx;
                    last_d     = win_idx;
                    hold_cnt_d = '0;
                end
            end
            S_BUSY: begin
                // A release wins over a simultaneous timeout, so preempt only fires
                // while the owner is still requesting.
                if (!owner_req || (hold_cnt_q == HOLD_LAST && others_req)) begin
                    grant_d    = '0;
                    preempt_d  = owner_req;
                    turn_cnt_d = '0;
                    state_d    = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + TURN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            last_q     <= LAST_RST;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            in_data_q  <= '0;
            in_valid_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.sel_o      = sel_q;
    assign bus.in_data_o  = in_data_q;
    assign bus.in_valid_o = in_valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.preempt_o  = preempt_q;

    // Output pads carry the owner's data only while it actually holds the bus.
    assign bus.mux_o = (state_q == S_BUSY) ? bus.src_data_i[sel_q*OUT_W +: OUT_W] : '0;

endmodule

// File: tb/tb_pad_mux_arbiter.sv
// Bench for pad_mux_arbiter: directed scenarios plus randomized traffic, all checked
// against an owner/gap reference model kept here.
module tb_pad_mux_arbiter;

    localparam int unsigned N           = 4;
    localparam int unsigned OUT_W       = 18;
    localparam int unsigned IN_W        = 22;
    localparam int unsigned MAX_HOLD    = 4;
    localparam int unsigned TURN_CYCLES = 2;

    logic clk;
    logic rst;

    int n_chk;
    int n_pass;

    // Reference model: who owns the bus, for how many cycles, and how many dead cycles remain.
    int              m_owner;
    int              m_last;
    int              m_held;
    int              m_gap;
    logic [1:0]      m_sel;
    logic            m_preempt;
    logic [IN_W-1:0] m_in_data;
    logic [N-1:0]    m_in_valid;

    pad_mux_if #(.N(N), .OUT_W(OUT_W), .IN_W(IN_W)) bus ();

    pad_mux_arbiter #(
        .N(N), .OUT_W(OUT_W), .IN_W(IN_W), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_grant();
        if (m_owner < 0) return '0;
        return N'(1) << m_owner;
    endfunction

    function automatic int owner_of(input logic [N-1:0] g);
        int o;
        o = -1;
        for (int k = 0; k < N; k++) if (g[k]) o = k;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [N-1:0] g;
        g = m_grant();
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_held = 0; m_gap = 0;
            m_sel = '0; m_preempt = 1'b0; m_in_data = '0; m_in_valid = '0;
            return;
        end
        m_in_valid = g;
        m_in_data  = bus.pad_in_i;
        m_preempt  = 1'b0;
        if (m_owner >= 0) begin
            if (!bus.req_i[m_owner]) begin
                m_owner = -1;
                m_gap   = TURN_CYCLES;
            end else if (m_held >= MAX_HOLD && (bus.req_i & ~g) != '0) begin
                m_preempt = 1'b1;
                m_owner   = -1;
                m_gap     = TURN_CYCLES;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.enable_i && (bus.req_i != '0)) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (bus.req_i[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_sel   = 2'(c);
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [OUT_W-1:0] exp_mux;
        exp_mux = '0;
        if (m_owner >= 0) exp_mux = bus.src_data_i[m_owner*OUT_W +: OUT_W];
        chk("grant",    64'(bus.grant_o),    64'(m_grant()));
        chk("sel",      64'(bus.sel_o),      64'(m_sel));
        chk("mux",      64'(bus.mux_o),      64'(exp_mux));
        chk("in_data",  64'(bus.in_data_o),  64'(m_in_data));
        chk("in_valid", 64'(bus.in_valid_o), 64'(m_in_valid));
        chk("busy",     64'(bus.busy_o),     64'((m_owner >= 0) || (m_gap > 0)));
        chk("preempt",  64'(bus.preempt_o),  64'(m_preempt));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge, new pad data.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        bus.pad_in_i = IN_W'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int rises[$];
        int span;
        int preempts;
        int falls;
        logic [N-1:0] prev_g;

        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        bus.enable_i = 1'b1;
        bus.req_i    = '0;
        bus.pad_in_i = IN_W'($urandom);
        for (int k = 0; k < N; k++) bus.src_data_i[k*OUT_W +: OUT_W] = OUT_W'($urandom);
        m_owner = -1; m_last = N - 1; m_held = 0; m_gap = 0;
        m_sel = '0; m_preempt = 1'b0; m_in_data = '0; m_in_valid = '0;

        // Reset state, then first grant goes to requester 0.
        @(negedge clk);
        do_reset();
        chk("rst_grant", 64'(bus.grant_o), 64'h0);
        chk("rst_busy",  64'(bus.busy_o),  64'h0);
        bus.req_i = 4'b0101;
        cycle();
        chk("t1_grant", 64'(bus.grant_o), 64'b0001);
        chk("t1_sel",   64'(bus.sel_o),   64'h0);
        chk("t1_mux",   64'(bus.mux_o),   64'(bus.src_data_i[OUT_W-1:0]));

        // Release by requester 0: three dead cycles, then requester 2.
        cycle(); cycle();
        bus.req_i = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t2_gap", 64'(bus.grant_o), 64'h0);
        end
        cycle();
        chk("t2_grant", 64'(bus.grant_o), 64'b0100);
        chk("t2_sel",   64'(bus.sel_o),   64'h2);

        // All requesting: each owner held MAX_HOLD cycles, preempted, order 0,1,2,3,0.
        do_reset();
        bus.req_i = 4'b1111;
        prev_g = '0; span = 0; preempts = 0; falls = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (bus.grant_o != '0 && prev_g == '0) rises.push_back(owner_of(bus.grant_o));
            if (bus.grant_o != '0) span++;
            if (bus.grant_o == '0 && prev_g != '0) begin
                chk("t3_span", 64'(span), 64'(MAX_HOLD));
                span = 0;
                falls++;
            end
            if (bus.preempt_o) preempts++;
            prev_g = bus.grant_o;
        end
        chk("t3_rises", 64'(rises.size() >= 5), 64'h1);
        for (int k = 0; k < 5 && k < rises.size(); k++) chk("t3_order", 64'(rises[k]), 64'(k % N));
        chk("t3_preempts", 64'(preempts), 64'(falls));

        // Sole requester is never preempted.
        do_reset();
        bus.req_i = 4'b0010;
        cycle();
        preempts = 0;
        for (int c = 0; c < 99; c++) begin
            cycle();
            chk("t4_grant", 64'(bus.grant_o), 64'b0010);
            if (bus.preempt_o) preempts++;
        end
        chk("t4_preempts", 64'(preempts), 64'h0);

        // Reset mid-transfer clears outputs and restores requester 0 priority.
        for (int k = 0; k < N; k++) bus.src_data_i[k*OUT_W +: OUT_W] = 18'h3FFFF;
        cycle();
        chk("t5_mux_busy", 64'(bus.mux_o), 64'h3FFFF);
        do_reset();
        chk("t5_grant", 64'(bus.grant_o), 64'h0);
        chk("t5_mux",   64'(bus.mux_o),   64'h0);
        bus.req_i = 4'b1001;
        cycle();
        chk("t5_winner", 64'(bus.grant_o), 64'b0001);

        // enable_i gating and in_valid_o delay.
        do_reset();
        bus.enable_i = 1'b0;
        bus.req_i    = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t6_blocked", 64'(bus.grant_o), 64'h0);
        end
        bus.enable_i = 1'b1;
        cycle();
        chk("t6_grant",  64'(bus.grant_o),    64'b0010);
        chk("t6_valid0", 64'(bus.in_valid_o), 64'h0);
        cycle();
        chk("t6_valid1", 64'(bus.in_valid_o), 64'b0010);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) bus.req_i[k] = ~bus.req_i[k];
                bus.src_data_i[k*OUT_W +: OUT_W] = OUT_W'($urandom);
            end
            bus.enable_i = ($urandom_range(7) != 0);
            rst = ($urandom_range(63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
